// File: rtl/ifu_prefetch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : ifu_prefetch                                                     |
// | Purpose  : Instruction prefetch unit with credit-based in-order fetch queue  |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module ifu_prefetch #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_rtvec,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_W-1:0]    ifu_req_pc,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic [INSTR_W-1:0] ifu_rsp_instr,
  output logic               ifu_o_valid,
  input  logic               ifu_o_ready,
  output logic [INSTR_W-1:0] ifu_o_ir,
  output logic [PC_W-1:0]    ifu_o_pc,
  output logic [4:0]         ifu_o_rs1idx,
  output logic [4:0]         ifu_o_rs2idx,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  localparam logic [OW-1:0] c_max_out = OW'(MAX_OUT);
  localparam logic [CW:0]   c_depth   = (CW + 1)'(DEPTH);
  localparam logic [PC_W-1:0] c_pc_step = PC_W'(4);

  logic [PC_W-1:0]    r_fetch_pc;
  logic [PC_W-1:0]    r_rsp_pc;
  logic [CW-1:0]      r_count;
  logic [OW-1:0]      r_out;
  logic [OW-1:0]      r_drop;
  logic               r_boot;
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [INSTR_W-1:0] r_q_ir [DEPTH];
  logic [PC_W-1:0]    r_q_pc [DEPTH];

  logic               w_req_fire;
  logic               w_rsp_fire;
  logic               w_push;
  logic               w_pop;
  logic [CW:0]        w_reserved;
  logic [OW-1:0]      w_out_nxt;

  // Requests are only issued while a queue slot is reserved for every in-flight fetch.
  assign w_reserved    = (CW + 1)'(r_count) + (CW + 1)'(r_out);
  assign ifu_req_valid = !r_boot && !redirect_valid && (r_out < c_max_out) && (w_reserved < c_depth);
  assign ifu_req_pc    = r_fetch_pc;
  assign ifu_rsp_ready = (r_out != '0);
  assign ifu_o_valid   = (r_count != '0);
  assign ifu_o_ir      = ifu_o_valid ? r_q_ir[r_rptr] : '0;
  assign ifu_o_pc      = ifu_o_valid ? r_q_pc[r_rptr] : '0;
  assign ifu_o_rs1idx  = ifu_o_ir[19:15];
  assign ifu_o_rs2idx  = ifu_o_ir[24:20];

  assign w_req_fire = ifu_req_valid && ifu_req_ready;
  assign w_rsp_fire = ifu_rsp_valid && ifu_rsp_ready;
  assign w_push     = w_rsp_fire && (r_drop == '0) && !redirect_valid;
  assign w_pop      = ifu_o_valid && ifu_o_ready && !redirect_valid;
  assign w_out_nxt  = r_out + OW'(w_req_fire) - OW'(w_rsp_fire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= '0;
      r_rsp_pc   <= '0;
      r_count    <= '0;
      r_out      <= '0;
      r_drop     <= '0;
      r_boot     <= 1'b1;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else if (redirect_valid) begin
      // Every request still in flight after this edge belongs to the old stream.
      r_fetch_pc <= redirect_pc;
      r_rsp_pc   <= redirect_pc;
      r_count    <= '0;
      r_out      <= w_out_nxt;
      r_drop     <= r_out - OW'(w_rsp_fire);
      r_boot     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else if (r_boot) begin
      r_fetch_pc <= pc_rtvec;
      r_rsp_pc   <= pc_rtvec;
      r_boot     <= 1'b0;
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + c_pc_step;
      end
      r_out <= w_out_nxt;
      if (w_rsp_fire && (r_drop != '0)) begin
        r_drop <= r_drop - OW'(1);
      end
      if (w_push) begin
        r_wptr   <= r_wptr + AW'(1);
        r_rsp_pc <= r_rsp_pc + c_pc_step;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_ir[r_wptr] <= ifu_rsp_instr;
      r_q_pc[r_wptr] <= r_rsp_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_ifu_prefetch                                                  |
// | Purpose  : Self-checking bench for ifu_prefetch with an in-order memory      |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_ifu_prefetch;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [PC_W-1:0]    pc_rtvec = '0;
  logic               ifu_req_valid;
  logic               ifu_req_ready = 1'b0;
  logic [PC_W-1:0]    ifu_req_pc;
  logic               ifu_rsp_valid = 1'b0;
  logic               ifu_rsp_ready;
  logic [INSTR_W-1:0] ifu_rsp_instr = '0;
  logic               ifu_o_valid;
  logic               ifu_o_ready = 1'b0;
  logic [INSTR_W-1:0] ifu_o_ir;
  logic [PC_W-1:0]    ifu_o_pc;
  logic [4:0]         ifu_o_rs1idx;
  logic [4:0]         ifu_o_rs2idx;
  logic               redirect_valid = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;

  ifu_prefetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .pc_rtvec(pc_rtvec),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_instr(ifu_rsp_instr),
    .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_ir(ifu_o_ir), .ifu_o_pc(ifu_o_pc),
    .ifu_o_rs1idx(ifu_o_rs1idx), .ifu_o_rs2idx(ifu_o_rs2idx),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_req = 0;
  int n_rsp = 0;
  logic [PC_W-1:0] pc_q [$];
  int due_q [$];
  bit hold = 0;
  bit rr_rand = 0;
  bit rsp_rand = 0;
  bit rr_cfg = 1;
  int max_lat = 1;

  // Memory contents: a fixed scramble of the address, so every PC has a distinct instruction.
  function automatic logic [INSTR_W-1:0] f_instr(input logic [PC_W-1:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic mem_drive();
    ifu_req_ready = rr_rand ? ($urandom_range(3) != 0) : rr_cfg;
    if (!hold && pc_q.size() > 0 && due_q[0] <= cyc && (!rsp_rand || $urandom_range(2) != 0)) begin
      ifu_rsp_valid = 1'b1;
      ifu_rsp_instr = f_instr(pc_q[0]);
    end else begin
      ifu_rsp_valid = 1'b0;
      ifu_rsp_instr = $urandom;
    end
  endtask

  // One clock: sample handshakes before the edge, update the in-order memory after it.
  task automatic tick();
    logic rf, sf;
    logic [PC_W-1:0] p;
    #1;
    rf = ifu_req_valid && ifu_req_ready;
    sf = ifu_rsp_valid && ifu_rsp_ready;
    p  = ifu_req_pc;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      pc_q.delete();
      due_q.delete();
    end else begin
      if (sf) begin
        void'(pc_q.pop_front());
        void'(due_q.pop_front());
        n_rsp++;
      end
      if (rf) begin
        pc_q.push_back(p);
        due_q.push_back(cyc + int'($urandom_range(max_lat - 1, 0)));
        n_req++;
      end
    end
    mem_drive();
    #1;
  endtask

  task automatic do_reset(input logic [PC_W-1:0] base);
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    ifu_o_ready = 1'b0;
    pc_rtvec = base;
    hold = 0; rr_rand = 0; rsp_rand = 0; rr_cfg = 1; max_lat = 1;
    pc_q.delete();
    due_q.delete();
    ifu_rsp_valid = 1'b0;
    tick();
    tick();
    n_req = 0;
    n_rsp = 0;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pc_rtvec = 32'hDEAD_BEE0;
    tick();
    tick();
    checks++; if (ifu_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b exp=0", ifu_req_valid); end
    checks++; if (ifu_rsp_ready !== 1'b0) begin failures++; $display("FAIL reset_rsp_ready got=%0b exp=0", ifu_rsp_ready); end
    checks++; if (ifu_o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%0b exp=0", ifu_o_valid); end
    checks++; if (ifu_req_pc !== '0) begin failures++; $display("FAIL reset_req_pc got=%h exp=0", ifu_req_pc); end
    checks++; if (ifu_o_pc !== '0) begin failures++; $display("FAIL reset_o_pc got=%h exp=0", ifu_o_pc); end
  endtask

  task automatic test_boot();
    do_reset(32'h8000_0000);
    checks++; if (ifu_req_valid !== 1'b0) begin failures++; $display("FAIL boot_cycle_req_valid got=%0b exp=0", ifu_req_valid); end
    checks++; if (ifu_rsp_ready !== 1'b0) begin failures++; $display("FAIL boot_cycle_rsp_ready got=%0b exp=0", ifu_rsp_ready); end
    checks++; if (ifu_o_valid !== 1'b0) begin failures++; $display("FAIL boot_cycle_o_valid got=%0b exp=0", ifu_o_valid); end
    tick();
    checks++; if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h8000_0000) begin
      failures++; $display("FAIL boot_first_req got valid=%0b pc=%h exp valid=1 pc=80000000", ifu_req_valid, ifu_req_pc); end
    tick();
    checks++; if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h8000_0004) begin
      failures++; $display("FAIL boot_second_req got valid=%0b pc=%h exp valid=1 pc=80000004", ifu_req_valid, ifu_req_pc); end
  endtask

  task automatic test_backpressure();
    logic [PC_W-1:0] base = 32'h0000_1000;
    do_reset(base);
    repeat (12) tick();
    checks++; if (n_req != DEPTH) begin failures++; $display("FAIL bp_req_count got=%0d exp=%0d", n_req, DEPTH); end
    checks++; if (ifu_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%0b exp=0", ifu_req_valid); end
    checks++; if (ifu_o_valid !== 1'b1) begin failures++; $display("FAIL bp_o_valid got=%0b exp=1", ifu_o_valid); end
    ifu_o_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (ifu_o_valid !== 1'b1 || ifu_o_pc !== base + 4 * i || ifu_o_ir !== f_instr(base + 4 * i)) begin
        failures++; $display("FAIL bp_drain[%0d] got v=%0b pc=%h ir=%h exp pc=%h ir=%h", i, ifu_o_valid, ifu_o_pc, ifu_o_ir, base + 4 * i, f_instr(base + 4 * i)); end
      tick();
    end
    ifu_o_ready = 1'b0;
  endtask

  task automatic test_streaming();
    logic [PC_W-1:0] exp_pc = 32'h0000_4000;
    int w = 0;
    do_reset(exp_pc);
    ifu_o_ready = 1'b1;
    while (!ifu_o_valid && w < 10) begin tick(); w++; end
    for (int i = 0; i < 16; i++) begin
      checks++; if (ifu_o_valid !== 1'b1 || ifu_o_pc !== exp_pc || ifu_o_ir !== f_instr(exp_pc)) begin
        failures++; $display("FAIL stream[%0d] got v=%0b pc=%h exp pc=%h", i, ifu_o_valid, ifu_o_pc, exp_pc); end
      exp_pc += 4;
      tick();
    end
  endtask

  task automatic test_redirect_inflight();
    int w = 0;
    do_reset(32'h0000_2000);
    hold = 1;
    ifu_o_ready = 1'b1;
    while (pc_q.size() < 2 && w < 10) begin tick(); w++; end
    checks++; if (pc_q.size() != 2) begin failures++; $display("FAIL rif_outstanding got=%0d exp=2", pc_q.size()); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1;
    checks++; if (ifu_req_valid !== 1'b0) begin failures++; $display("FAIL rif_req_valid_in_redirect got=%0b exp=0", ifu_req_valid); end
    tick();
    redirect_valid = 1'b0;
    hold = 0;
    mem_drive();
    w = 0;
    while (!ifu_o_valid && w < 20) begin tick(); w++; end
    checks++; if (ifu_o_valid !== 1'b1 || ifu_o_pc !== 32'h100 || ifu_o_ir !== f_instr(32'h100)) begin
      failures++; $display("FAIL rif_first_after got v=%0b pc=%h ir=%h exp pc=00000100 ir=%h", ifu_o_valid, ifu_o_pc, ifu_o_ir, f_instr(32'h100)); end
  endtask

  task automatic test_redirect_simul();
    int w = 0;
    do_reset(32'h0000_3000);
    hold = 1;
    mem_drive();
    while (n_req < 2 && w < 10) begin tick(); w++; end
    rr_cfg = 0; hold = 0; mem_drive();
    while (n_rsp < 2 && w < 20) begin tick(); w++; end
    rr_cfg = 1; hold = 1; mem_drive();
    while (n_req < 4 && w < 30) begin tick(); w++; end
    rr_cfg = 0; mem_drive();
    checks++; if (n_req != 4 || n_rsp != 2 || ifu_o_valid !== 1'b1) begin
      failures++; $display("FAIL rs_setup got req=%0d rsp=%0d ov=%0b exp req=4 rsp=2 ov=1", n_req, n_rsp, ifu_o_valid); end
    hold = 0;
    mem_drive();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    ifu_o_ready = 1'b1;
    #1;
    checks++; if (ifu_req_valid !== 1'b0) begin failures++; $display("FAIL rs_req_valid got=%0b exp=0", ifu_req_valid); end
    checks++; if (ifu_rsp_ready !== 1'b1 || ifu_rsp_valid !== 1'b1) begin
      failures++; $display("FAIL rs_rsp_fire got ready=%0b valid=%0b exp 1/1", ifu_rsp_ready, ifu_rsp_valid); end
    tick();
    redirect_valid = 1'b0;
    ifu_o_ready = 1'b0;
    #1;
    checks++; if (ifu_o_valid !== 1'b0) begin failures++; $display("FAIL rs_queue_empty got=%0b exp=0", ifu_o_valid); end
    checks++; if (ifu_rsp_ready !== 1'b1) begin failures++; $display("FAIL rs_one_outstanding got=%0b exp=1", ifu_rsp_ready); end
    checks++; if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h300) begin
      failures++; $display("FAIL rs_refetch got v=%0b pc=%h exp v=1 pc=00000300", ifu_req_valid, ifu_req_pc); end
    rr_cfg = 1;
    mem_drive();
    ifu_o_ready = 1'b1;
    w = 0;
    while (!ifu_o_valid && w < 20) begin tick(); w++; end
    checks++; if (ifu_o_valid !== 1'b1 || ifu_o_pc !== 32'h300 || ifu_o_ir !== f_instr(32'h300)) begin
      failures++; $display("FAIL rs_first_after got v=%0b pc=%h ir=%h exp pc=00000300 ir=%h", ifu_o_valid, ifu_o_pc, ifu_o_ir, f_instr(32'h300)); end
  endtask

  task automatic test_async_reset();
    int w = 0;
    do_reset(32'h0000_5000);
    ifu_o_ready = 1'b1;
    repeat (8) tick();
    checks++; if (ifu_o_valid !== 1'b1) begin failures++; $display("FAIL ar_streaming got=%0b exp=1", ifu_o_valid); end
    #2;
    rst = 1'b0;
    pc_q.delete();
    due_q.delete();
    ifu_rsp_valid = 1'b0;
    #1;
    checks++; if (ifu_req_valid !== 1'b0 || ifu_rsp_ready !== 1'b0 || ifu_o_valid !== 1'b0) begin
      failures++; $display("FAIL ar_valids got req=%0b rsp=%0b o=%0b exp 0/0/0", ifu_req_valid, ifu_rsp_ready, ifu_o_valid); end
    checks++; if (ifu_req_pc !== '0 || ifu_o_pc !== '0) begin
      failures++; $display("FAIL ar_pcs got req_pc=%h o_pc=%h exp 0/0", ifu_req_pc, ifu_o_pc); end
    pc_rtvec = 32'h0000_6000;
    tick();
    tick();
    rst = 1'b1;
    while (!ifu_o_valid && w < 10) begin tick(); w++; end
    checks++; if (ifu_o_valid !== 1'b1 || ifu_o_pc !== 32'h6000 || ifu_o_ir !== f_instr(32'h6000)) begin
      failures++; $display("FAIL ar_resume got v=%0b pc=%h exp pc=00006000", ifu_o_valid, ifu_o_pc); end
  endtask

  // Architectural model: consumed PCs run +4 from the boot/redirect target; fetches likewise.
  task automatic test_random();
    logic [PC_W-1:0] exp_pc, exp_f, base;
    logic [INSTR_W-1:0] exp_ir;
    bit redir, popping, reqf;
    int pops = 0;
    base = $urandom & 32'hFFFF_FFFC;
    do_reset(base);
    rr_rand = 1; rsp_rand = 1; max_lat = 3;
    exp_pc = base;
    exp_f = base;
    tick();
    for (int i = 0; i < 600; i++) begin
      redir = ($urandom_range(24) == 0);
      redirect_valid = redir;
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      ifu_o_ready = $urandom_range(1) != 0;
      #1;
      if (ifu_o_valid) begin
        exp_ir = f_instr(exp_pc);
        checks++; if (ifu_o_pc !== exp_pc || ifu_o_ir !== exp_ir) begin
          failures++; $display("FAIL rnd_head[%0d] got pc=%h ir=%h exp pc=%h ir=%h", i, ifu_o_pc, ifu_o_ir, exp_pc, exp_ir); end
        checks++; if (ifu_o_rs1idx !== exp_ir[19:15] || ifu_o_rs2idx !== exp_ir[24:20]) begin
          failures++; $display("FAIL rnd_regidx[%0d] got rs1=%0d rs2=%0d exp rs1=%0d rs2=%0d", i, ifu_o_rs1idx, ifu_o_rs2idx, exp_ir[19:15], exp_ir[24:20]); end
      end
      if (ifu_req_valid && ifu_req_ready) begin
        checks++; if (ifu_req_pc !== exp_f) begin failures++; $display("FAIL rnd_req_pc[%0d] got=%h exp=%h", i, ifu_req_pc, exp_f); end
      end
      checks++; if (ifu_rsp_ready !== (pc_q.size() != 0)) begin
        failures++; $display("FAIL rnd_rsp_ready[%0d] got=%0b exp=%0b", i, ifu_rsp_ready, pc_q.size() != 0); end
      if (ifu_req_valid) begin
        checks++; if (redir || pc_q.size() >= MAX_OUT) begin
          failures++; $display("FAIL rnd_req_gate[%0d] got req_valid=1 exp 0 (redir=%0b out=%0d)", i, redir, pc_q.size()); end
      end
      popping = ifu_o_valid && ifu_o_ready && !redir;
      reqf = ifu_req_valid && ifu_req_ready;
      tick();
      if (redir) begin
        exp_pc = redirect_pc;
        exp_f = redirect_pc;
      end else begin
        if (popping) begin exp_pc += 4; pops++; end
        if (reqf) exp_f += 4;
      end
    end
    redirect_valid = 1'b0;
    checks++; if (pops < 50) begin failures++; $display("FAIL rnd_progress got pops=%0d exp >=50", pops); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    test_streaming();
    test_redirect_inflight();
    test_redirect_simul();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning PC and fetch-address width.
REQ-002 SHALL have parameter INSTR_W, default 32, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning instruction-queue entries; power of two, >= 2.
REQ-004 SHALL have parameter MAX_OUT, default 2, meaning maximum in-flight fetch requests; 1 <= MAX_OUT <= DEPTH.
REQ-005 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-006 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port pc_rtvec  input  PC_W  boot PC; held stable while rst is low.
REQ-008 SHALL have port ifu_req_valid  output  1  fetch request valid.
REQ-009 SHALL have port ifu_req_ready  input  1  memory accepts the request.
REQ-010 SHALL have port ifu_req_pc  output  PC_W  fetch address.
REQ-011 SHALL have port ifu_rsp_valid  input  1  memory response valid; responses return in request order.
REQ-012 SHALL have port ifu_rsp_ready  output  1  response accept.
REQ-013 SHALL have port ifu_rsp_instr  input  INSTR_W  fetched instruction.
REQ-014 SHALL have port ifu_o_valid  output  1  queue head valid.
REQ-015 SHALL have port ifu_o_ready  input  1  consumer takes the head.
REQ-016 SHALL have port ifu_o_ir  output  INSTR_W  head instruction.
REQ-017 SHALL have port ifu_o_pc  output  PC_W  head instruction PC.
REQ-018 SHALL have port ifu_o_rs1idx  output  5  ifu_o_ir[19:15].
REQ-019 SHALL have port ifu_o_rs2idx  output  5  ifu_o_ir[24:20].
REQ-020 SHALL have port redirect_valid  input  1  flush and refetch from redirect_pc.
REQ-021 SHALL have port redirect_pc  input  PC_W  new fetch PC.

Function
REQ-022 SHALL define the following events: req_fire = ifu_req_valid & ifu_req_ready; rsp_fire = ifu_rsp_valid & ifu_rsp_ready; pop = ifu_o_valid & ifu_o_ready.
REQ-023 SHALL keep the following state: fetch_pc, rsp_pc, count (0..DEPTH), outstanding (0..MAX_OUT), drop_cnt (0..MAX_OUT, never exceeding outstanding), and a boot flag.
REQ-024 SHALL, in the first cycle after reset release (boot=1), load fetch_pc and rsp_pc from pc_rtvec, clear boot, and hold ifu_req_valid at 0.
REQ-025 SHALL drive ifu_req_valid = !boot & !redirect_valid & (outstanding < MAX_OUT) & (count + outstanding < DEPTH), so every in-flight request always has a reserved queue slot.
REQ-026 SHALL drive ifu_req_pc = fetch_pc.
REQ-027 SHALL, on req_fire, advance fetch_pc by 4 (modulo 2^PC_W).
REQ-028 SHALL drive ifu_rsp_ready = (outstanding != 0); responses arriving while outstanding = 0 are ignored.
REQ-029 SHALL update outstanding each cycle as outstanding + req_fire - rsp_fire.
REQ-030 SHALL, on rsp_fire with drop_cnt > 0 and no redirect, discard the response and decrement drop_cnt.
REQ-031 SHALL, on rsp_fire with drop_cnt = 0 and no redirect, write {ifu_rsp_instr, rsp_pc} at the tail, then advance rsp_pc by 4.
REQ-032 SHALL drive ifu_o_valid = (count != 0), with ifu_o_ir and ifu_o_pc taken from the head entry; latency from rsp_fire to ifu_o_valid is 1 cycle.
REQ-033 SHALL allow a push and a pop in the same cycle; count is then unchanged and the pointers wrap modulo DEPTH.
REQ-034 SHALL, on redirect_valid=1:
  - set count to 0, which empties the queue; the pop in that cycle is ignored;
  - set fetch_pc and rsp_pc to redirect_pc;
  - set drop_cnt to outstanding - rsp_fire;
  - discard any response accepted in that cycle.
REQ-035 SHALL apply a redirect arriving while drop_cnt > 0 under the same rule as REQ-034; the new drop_cnt covers all prior in-flight requests.
REQ-036 SHALL allow redirect_valid during boot, with priority over pc_rtvec.

Reset
REQ-037 SHALL, while rst=0, asynchronously set count, outstanding, drop_cnt and the read/write pointers to 0, set boot to 1, and set fetch_pc and rsp_pc to 0.
REQ-038 SHALL hold ifu_req_valid=0, ifu_rsp_ready=0 and ifu_o_valid=0 during reset and in the boot cycle; ifu_req_pc=0 and ifu_o_pc=0 during reset.
REQ-039 SHALL, on reset mid-operation, lose all queued and in-flight state; the memory side is reset together with this block.

Verification
REQ-040 SHALL cover boot: pc_rtvec=0x8000_0000, ifu_req_ready=1 -> first ifu_req_pc 0x8000_0000 in cycle 2 after release, then 0x8000_0004.
REQ-041 SHALL cover backpressure: ifu_o_ready=0, 1-cycle memory, DEPTH=4 -> exactly 4 requests issued, ifu_req_valid then 0, queue holds PCs +0, +4, +8, +C in order.
REQ-042 SHALL cover streaming: ifu_o_ready=1, memory latency 1 -> one instruction popped per cycle and ifu_o_pc strictly +4 per pop.
REQ-043 SHALL cover redirect in flight: 2 outstanding, redirect_pc=0x100 -> both old responses dropped, next ifu_o_pc=0x100 with the instruction fetched at 0x100.
REQ-044 SHALL cover redirect with simultaneous rsp_fire and pop: count=2, outstanding=2 -> count=0, drop_cnt=1, and ifu_req_valid=0 in the redirect cycle.
REQ-045 SHALL cover async reset mid-stream: rst low between clock edges -> all outputs 0 immediately, then resume from pc_rtvec.
